// File: rtl/crc5_pkg.sv
// crc5_pkg: shared USB CRC5 constants, polynomial step and checker state type
package crc5_pkg;
  localparam logic [4:0] CRC5_INIT = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} crc5_state_t;
  function automatic logic [4:0] crc5_next(input logic [4:0] r, input logic b);
    return {r[3], r[2], r[1] ^ r[4] ^ b, r[0], r[4] ^ b};
  endfunction
endpackage

// File: rtl/crc5_check_if.sv
// crc5_check_if: token-body bit stream in, check result out; err_cnt present when CRC5_ERR_CNT_EN is defined
interface crc5_check_if #(parameter int DATA_BITS = 11);
  logic chk_start;
  logic s_in;
  logic s_valid;
  logic chk_abort;
  logic chk_ready;
  logic chk_done;
  logic crc_ok;
  logic [DATA_BITS-1:0] payload;
  logic [4:0] crc_rx;
`ifdef CRC5_ERR_CNT_EN
  logic [7:0] err_cnt;
  modport master (output chk_start, s_in, s_valid, chk_abort,
                  input chk_ready, chk_done, crc_ok, payload, crc_rx, err_cnt);
  modport slave (input chk_start, s_in, s_valid, chk_abort,
                 output chk_ready, chk_done, crc_ok, payload, crc_rx, err_cnt);
`else
  modport master (output chk_start, s_in, s_valid, chk_abort,
                  input chk_ready, chk_done, crc_ok, payload, crc_rx);
  modport slave (input chk_start, s_in, s_valid, chk_abort,
                 output chk_ready, chk_done, crc_ok, payload, crc_rx);
`endif
endinterface

// File: rtl/crc5_lfsr.sv
// crc5_lfsr: 5-bit USB CRC5 register with init load and per-bit shift enable
module crc5_lfsr
  import crc5_pkg::*;
#(
  parameter logic [4:0] INIT = CRC5_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic       b,
  output logic [4:0] r
);
  // Reload on a new check, otherwise advance one bit per enabled cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= INIT;
    else if (load) r <= INIT;
    else if (shift) r <= crc5_next(r, b);
endmodule

// File: rtl/crc5_check.sv
// crc5_check: USB token CRC5 receive checker; CRC5_ERR_CNT_EN adds a saturating bad-CRC counter
module crc5_check
  import crc5_pkg::*;
#(
  parameter int DATA_BITS = 11,
  parameter logic [4:0] CRC_INIT = CRC5_INIT,
  parameter logic [4:0] CRC_RESIDUAL = CRC5_RESIDUAL
) (
  input logic clk,
  input logic rst,
  crc5_check_if.slave bus
);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  if (DATA_BITS < 2 || DATA_BITS > 15) begin : g_bad_width
    $error("crc5_check: DATA_BITS must be 2..15 so the 4-bit counter never wraps");
  end
  crc5_state_t state, state_nx;
  logic [3:0] cnt;
  logic [4:0] lfsr;
  logic [DATA_BITS-1:0] payload;
  logic [4:0] crc_rx;
  logic crc_ok, chk_ready, chk_done;
  logic start, abort, acc, last_data, last_crc;
  assign start = state == IDLE && bus.chk_start;
  assign abort = state != IDLE && bus.chk_abort;
  assign acc = bus.s_valid && !abort;
  assign last_data = state == DATA && acc && cnt == LAST;
  assign last_crc = state == CRC && acc && cnt == 4'd4;
  crc5_lfsr #(.INIT(CRC_INIT)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .load(start),
    .shift(acc && (state == DATA || state == CRC)),
    .b(bus.s_in),
    .r(lfsr)
  );
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Next state and status; abort wins over a coincident final bit
  always_comb begin
    state_nx = abort ? IDLE : start ? DATA : last_data ? CRC : last_crc ? DONE : state == DONE ? IDLE : state;
    chk_ready = state == IDLE;
    chk_done = state == DONE && !bus.chk_abort;
  end
  // Capture payload/CRC bits and judge the residual as the final bit lands so crc_ok is valid with chk_done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      payload <= '0;
      crc_rx <= '0;
      crc_ok <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
        payload <= '0;
        crc_rx <= '0;
      end else if (state == DATA && acc) begin
        payload <= {bus.s_in, payload[DATA_BITS-1:1]};
        cnt <= last_data ? 4'd0 : cnt + 4'd1;
      end else if (state == CRC && acc) begin
        crc_rx <= {crc_rx[3:0], bus.s_in};
        cnt <= cnt + 4'd1;
      end
      crc_ok <= abort ? 1'b0 : last_crc ? crc5_next(lfsr, bus.s_in) == CRC_RESIDUAL : crc_ok;
    end
  assign bus.chk_ready = chk_ready;
  assign bus.chk_done = chk_done;
  assign bus.crc_ok = crc_ok;
  assign bus.payload = payload;
  assign bus.crc_rx = crc_rx;
`ifdef CRC5_ERR_CNT_EN
  logic [7:0] err_cnt;
  // Count completed checks with a bad residual, saturating; aborted checks never reach chk_done
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (chk_done && lfsr != CRC_RESIDUAL && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  assign bus.err_cnt = err_cnt;
`endif
endmodule
